// File: rtl/m68k_bus_responder_pkg.sv
// Shared definitions for the M68K bus responder: FSM encoding,
// register-index constants and the idle interrupt-line value.
package m68k_bus_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Register window index (A[3:1]) of the IRQ control word and the ID word.
  localparam logic [2:0] IDX_IRQ = 3'd6;
  localparam logic [2:0] IDX_ID  = 3'd7;

  // IPL lines are active-low; all ones means "no interrupt requested".
  localparam logic [2:0] IPL_IDLE = 3'b111;

endpackage

// File: rtl/m68k_resp_regs.sv
// Register file for the bus responder: six read/write words, the IRQ
// pending bit at index 6 and the read-only ID word at index 7.
module m68k_resp_regs
  import m68k_bus_responder_pkg::*;
#(
  parameter logic [15:0] ID_WORD = 16'hF1AC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [2:0]  idx,
  input  logic [15:0] wr_data,
  input  logic        wr_hi,
  input  logic        wr_lo,
  output logic [15:0] rd_data,
  output logic        irq_pending
);

  logic [15:0] mem [0:5];

  // Byte-lane writes into storage words and the IRQ pending bit.
  // NOTE: the storage is only six words, so it is reset like ordinary
  // flops; a larger array would normally be left unreset and mapped to RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) mem[i] <= '0;
      irq_pending <= 1'b0;
    end else if (wr_en) begin
      if (idx < IDX_IRQ) begin
        if (wr_hi) mem[idx][15:8] <= wr_data[15:8];
        if (wr_lo) mem[idx][7:0]  <= wr_data[7:0];
      end else if (idx == IDX_IRQ && wr_lo) begin
        irq_pending <= wr_data[0];
      end
      // Index 7 is the ID word: writes are silently dropped.
    end
  end

  // Read mux over the whole 8-word window.
  // NOTE: rd_data gets a default before the branches so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data = '0;
    if (idx < IDX_IRQ)       rd_data = mem[idx];
    else if (idx == IDX_IRQ) rd_data = {15'd0, irq_pending};
    else                     rd_data = ID_WORD;
  end

endmodule

// File: rtl/m68k_bus_responder.sv
// M68K asynchronous-bus slave exposing a 16-byte register window with
// optional wait states, DTACK handshake and a level interrupt request.
module m68k_bus_responder
  import m68k_bus_responder_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR   = 24'hEF0000,
  parameter int          WAIT_STATES = 0,
  parameter logic [2:0]  IPL_LEVEL   = 3'd2,
  parameter logic [15:0] ID_WORD     = 16'hF1AC
) (
  input  logic        M68K_CLK,
  input  logic        M68K_RESET_n,
  input  logic [23:1] M68K_A,
  input  logic [15:0] M68K_D_IN,
  output logic [15:0] M68K_D_OUT,
  output logic        M68K_D_OE,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  output logic        M68K_DTACK_n,
  output logic [2:0]  M68K_IPL_n
);

  // Counter preload: the WAIT state itself consumes one edge per count plus
  // the final edge at zero, giving WAIT_STATES extra edges in total.
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        qualify;
  logic        commit;
  logic [15:0] rd_data;
  logic        irq_pending;

  assign qualify = !M68K_AS_n && (!M68K_UDS_n || !M68K_LDS_n) &&
                   (M68K_A[23:4] == BASE_ADDR[23:4]);

  // Edge that enters ACK: the register access happens exactly here.
  assign commit = ((state == ST_IDLE) && qualify && (WAIT_STATES == 0)) ||
                  ((state == ST_WAIT) && !M68K_AS_n && (wait_cnt == 4'd0));

  m68k_resp_regs #(
    .ID_WORD (ID_WORD)
  ) u_regs (
    .clk         (M68K_CLK),
    .rst_n       (M68K_RESET_n),
    .wr_en       (commit && !M68K_RW),
    .idx         (M68K_A[3:1]),
    .wr_data     (M68K_D_IN),
    .wr_hi       (!M68K_UDS_n),
    .wr_lo       (!M68K_LDS_n),
    .rd_data     (rd_data),
    .irq_pending (irq_pending)
  );

  // Bus-cycle FSM with registered handshake, data and interrupt outputs.
  // NOTE: all state here uses non-blocking assignments so every output
  // reflects values sampled at the same edge, independent of statement order.
  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      M68K_DTACK_n <= 1'b1;
      M68K_D_OE    <= 1'b0;
      M68K_D_OUT   <= '0;
      M68K_IPL_n   <= IPL_IDLE;
    end else begin
      M68K_IPL_n <= irq_pending ? ~IPL_LEVEL : IPL_IDLE;
      if (commit) begin
        state        <= ST_ACK;
        wait_cnt     <= '0;
        M68K_DTACK_n <= 1'b0;
        M68K_D_OE    <= M68K_RW;
        M68K_D_OUT   <= M68K_RW ? rd_data : 16'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (qualify) begin
              state    <= ST_WAIT;
              wait_cnt <= WS_LOAD;
            end
          end
          ST_WAIT: begin
            if (M68K_AS_n) begin
              state    <= ST_IDLE;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt - 4'd1;
            end
          end
          ST_ACK: state <= ST_HOLD;
          ST_HOLD: begin
            if (M68K_AS_n) begin
              state        <= ST_IDLE;
              M68K_DTACK_n <= 1'b1;
              M68K_D_OE    <= 1'b0;
              M68K_D_OUT   <= '0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed self-checking bench for m68k_bus_responder. Three instances
// (0, 3 and 5 wait states) share the bus but have private AS_n strobes;
// expected read data come from a bench model via a scoreboard queue.
module tb_m68k_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:1] a = '0;
  logic [15:0] d_in = '0;
  logic        uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
  logic [2:0]  as_v = 3'b111;
  logic [2:0]  dtack_v, oe_v;
  logic [15:0] dout_v [3];
  logic [2:0]  ipl_v  [3];

  int total = 0;
  int bad   = 0;
  int ws_of [3] = '{0, 3, 5};

  logic [15:0] mdl [3][8];
  logic [15:0] exp_q [$];
  logic [2:0]  ipl_ack, ipl_hold;

  always #5 clk = ~clk;

  m68k_bus_responder #(.WAIT_STATES(0)) dut0 (
    .M68K_CLK(clk), .M68K_RESET_n(rst_n), .M68K_A(a), .M68K_D_IN(d_in),
    .M68K_D_OUT(dout_v[0]), .M68K_D_OE(oe_v[0]), .M68K_AS_n(as_v[0]),
    .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
    .M68K_DTACK_n(dtack_v[0]), .M68K_IPL_n(ipl_v[0]));

  m68k_bus_responder #(.WAIT_STATES(3)) dut1 (
    .M68K_CLK(clk), .M68K_RESET_n(rst_n), .M68K_A(a), .M68K_D_IN(d_in),
    .M68K_D_OUT(dout_v[1]), .M68K_D_OE(oe_v[1]), .M68K_AS_n(as_v[1]),
    .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
    .M68K_DTACK_n(dtack_v[1]), .M68K_IPL_n(ipl_v[1]));

  m68k_bus_responder #(.WAIT_STATES(5)) dut2 (
    .M68K_CLK(clk), .M68K_RESET_n(rst_n), .M68K_A(a), .M68K_D_IN(d_in),
    .M68K_D_OUT(dout_v[2]), .M68K_D_OE(oe_v[2]), .M68K_AS_n(as_v[2]),
    .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
    .M68K_DTACK_n(dtack_v[2]), .M68K_IPL_n(ipl_v[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 7; i++) mdl[d][i] = 16'h0000;
      mdl[d][7] = 16'hF1AC;
    end
  endtask

  function automatic logic [2:0] exp_ipl(input int d);
    return mdl[d][6][0] ? 3'b101 : 3'b111;
  endfunction

  // One complete bus cycle on instance d; model updated / expectation queued at issue.
  task automatic bus_cycle(input int d, input logic r, input logic [23:0] addr,
                           input logic [15:0] wd, input logic u_n, input logic l_n);
    int          edges = 0;
    bit          got = 0;
    logic [2:0]  idx = addr[3:1];
    logic [15:0] exp;
    a = addr[23:1]; rw = r; d_in = wd; uds_n = u_n; lds_n = l_n; as_v[d] = 1'b0;
    if (r) exp_q.push_back(mdl[d][idx]);
    else if (idx < 3'd6) begin
      if (!u_n) mdl[d][idx][15:8] = wd[15:8];
      if (!l_n) mdl[d][idx][7:0]  = wd[7:0];
    end else if (idx == 3'd6 && !l_n) mdl[d][6] = {15'd0, wd[0]};
    while (!got && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (dtack_v[d] == 1'b0) got = 1;
    end
    check("dtack_latency", edges, ws_of[d] + 1);
    if (r) exp = exp_q.pop_front();
    if (got) begin
      ipl_ack = ipl_v[d];
      if (r) begin
        check("read_data", dout_v[d], exp);
        check("read_oe", oe_v[d], 1);
      end else begin
        check("write_oe", oe_v[d], 0);
      end
      @(posedge clk); #1;
      ipl_hold = ipl_v[d];
      check("dtack_hold", dtack_v[d], 0);
    end
    as_v[d] = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    @(posedge clk); #1;
    check("dtack_release", dtack_v[d], 1);
    check("oe_release", oe_v[d], 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    int edges;
    mdl_reset();
    #12;
    check("rst_dtack", dtack_v[0], 1);
    check("rst_oe", oe_v[0], 0);
    check("rst_dout", dout_v[0], 0);
    check("rst_ipl", ipl_v[0], 3'b111);
    check("rst_dtack_ws3", dtack_v[1], 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ID read, zero wait states.
    bus_cycle(0, 1'b1, 24'hEF000E, 16'h0000, 1'b0, 1'b0);

    // Word write then read back with three wait states.
    bus_cycle(1, 1'b0, 24'hEF0002, 16'h1234, 1'b0, 1'b0);
    bus_cycle(1, 1'b1, 24'hEF0002, 16'h0000, 1'b0, 1'b0);

    // Byte lanes on reg0.
    bus_cycle(0, 1'b0, 24'hEF0000, 16'hAAAA, 1'b0, 1'b0);
    bus_cycle(0, 1'b0, 24'hEF0000, 16'h5566, 1'b1, 1'b0);
    bus_cycle(0, 1'b1, 24'hEF0000, 16'h0000, 1'b0, 1'b0);
    bus_cycle(0, 1'b0, 24'hEF0000, 16'h7788, 1'b0, 1'b1);
    bus_cycle(0, 1'b1, 24'hEF0000, 16'h0000, 1'b0, 1'b0);

    // ID word is read-only.
    bus_cycle(0, 1'b0, 24'hEF000E, 16'h0000, 1'b0, 1'b0);
    bus_cycle(0, 1'b1, 24'hEF000E, 16'h0000, 1'b0, 1'b0);

    // IRQ set: IPL still idle at the commit edge, asserted one edge later.
    bus_cycle(0, 1'b0, 24'hEF000C, 16'h0001, 1'b0, 1'b0);
    check("ipl_at_commit", ipl_ack, 3'b111);
    check("ipl_next_edge", ipl_hold, 3'b101);
    bus_cycle(0, 1'b1, 24'hEF000C, 16'h0000, 1'b0, 1'b0);
    bus_cycle(0, 1'b0, 24'hEF000C, 16'h0000, 1'b0, 1'b1);
    check("ipl_uds_only", ipl_v[0], exp_ipl(0));
    bus_cycle(0, 1'b0, 24'hEF000C, 16'h0000, 1'b0, 1'b0);
    check("ipl_cleared", ipl_v[0], exp_ipl(0));

    // Abort during wait states: no DTACK, no write.
    a = 24'hEF0004 >> 1; rw = 1'b0; d_in = 16'hBEEF; uds_n = 1'b0; lds_n = 1'b0;
    as_v[2] = 1'b0;
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (!dtack_v[2]) seen = 1; end
    as_v[2] = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (!dtack_v[2]) seen = 1; end
    check("abort_no_dtack", seen, 0);
    bus_cycle(2, 1'b1, 24'hEF0004, 16'h0000, 1'b0, 1'b0);

    // Address miss: no response at all.
    a = 24'hEE0000 >> 1; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_v[0] = 1'b0;
    seen = 0;
    repeat (6) begin @(posedge clk); #1; if (!dtack_v[0] || oe_v[0]) seen = 1; end
    check("miss_no_response", seen, 0);
    check("miss_dout", dout_v[0], 0);
    as_v[0] = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted while in HOLD.
    a = 24'hEF000E >> 1; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0; as_v[0] = 1'b0;
    edges = 0;
    while (dtack_v[0] && edges < 10) begin @(posedge clk); #1; edges++; end
    check("pre_reset_ack", dtack_v[0], 0);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_hold_dtack", dtack_v[0], 1);
    check("reset_hold_oe", oe_v[0], 0);
    check("reset_hold_dout", dout_v[0], 0);
    mdl_reset();
    as_v[0] = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", dtack_v[0], 1);
    bus_cycle(1, 1'b1, 24'hEF0002, 16'h0000, 1'b0, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
